// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//   - SPECIAL opcode and funct codes of the MDU instructions
//   - operation select encoding used by the combinational arithmetic block
//   - FSM state type and a small instruction decode helper
package e_mdu_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Arithmetic select: bit1 = divide, bit0 = unsigned. This matches funct[1:0]
    // of the four arithmetic instructions, so the funct bits feed it directly.
    localparam logic [1:0] ARITH_MULT  = 2'b00;
    localparam logic [1:0] ARITH_MULTU = 2'b01;
    localparam logic [1:0] ARITH_DIV   = 2'b10;
    localparam logic [1:0] ARITH_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic mul;
        logic div;
        logic mthi;
        logic mtlo;
        logic mfhi;
        logic mflo;
    } mdu_dec_t;

    function automatic mdu_dec_t mdu_decode(input logic [5:0] opcode, input logic [5:0] funct);
        mdu_dec_t d;
        logic     sp;
        sp     = (opcode == OP_SPECIAL);
        d.mul  = sp && ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU));
        d.div  = sp && ((funct == FUNCT_DIV)  || (funct == FUNCT_DIVU));
        d.mthi = sp && (funct == FUNCT_MTHI);
        d.mtlo = sp && (funct == FUNCT_MTLO);
        d.mfhi = sp && (funct == FUNCT_MFHI);
        d.mflo = sp && (funct == FUNCT_MFLO);
        return d;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational multiply/divide datapath.
//   op      in  2   operation select (ARITH_* in e_mdu_pkg)
//   a       in  32  rs operand (multiplicand / dividend)
//   b       in  32  rt operand (multiplier / divisor)
//   res_hi  out 32  product[63:32] or remainder
//   res_lo  out 32  product[31:0] or quotient
// A zero divisor yields zero results here; the caller decides what HI/LO keep.
// Signed 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
module mdu_arith
    import e_mdu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sb_safe;
    logic        [31:0] ub_safe;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               div_zero;
    logic               div_ovf;

    always_comb begin
        sa       = $signed(a);
        sb       = $signed(b);
        div_zero = (b == 32'd0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

        // Divide by 1 instead of 0 or -1 in the corner cases: it keeps the
        // operator well-defined, and for the overflow case a/1 already gives
        // the wrapped quotient 0x80000000 with remainder 0.
        sb_safe  = (div_zero || div_ovf) ? 32'sd1 : sb;
        ub_safe  = div_zero ? 32'd1 : b;

        prod_s   = 64'(sa) * 64'(sb);
        prod_u   = {32'd0, a} * {32'd0, b};

        // SV signed division truncates toward zero; remainder follows the dividend.
        quo_s    = sa / sb_safe;
        rem_s    = sa % sb_safe;
        quo_u    = a / ub_safe;
        rem_u    = a % ub_safe;

        res_hi   = 32'd0;
        res_lo   = 32'd0;
        case (op)
            ARITH_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            ARITH_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            ARITH_DIV: begin
                res_hi = div_zero ? 32'd0 : rem_s;
                res_lo = div_zero ? 32'd0 : quo_s;
            end
            default: begin
                res_hi = div_zero ? 32'd0 : rem_u;
                res_lo = div_zero ? 32'd0 : quo_u;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// The result of mult/multu/div/divu is computed at the start edge, held in
// pending registers and committed to HI/LO after a fixed latency.
//   clk        in   1   clock
//   reset      in   1   asynchronous active-low reset
//   E_Instr    in   32  instruction in E (all-zero = bubble)
//   E_RS       in   32  forwarded rs operand
//   E_RT       in   32  forwarded rt operand
//   MDU_start  out  1   arithmetic MDU op in E while idle
//   MDU_busy   out  1   operation in flight (decoded from the state register)
//   MDU_stall  out  1   MDU_start | MDU_busy
//   E_MDU_OUT  out  32  HI for mfhi, LO for mflo, else 0
//   E_HI       out  32  HI register
//   E_LO       out  32  LO register
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_Instr,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        MDU_start,
    output logic        MDU_busy,
    output logic        MDU_stall,
    output logic [31:0] E_MDU_OUT,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mdu_state_e       state;
    mdu_state_e       next_state;
    logic [CNT_W-1:0] count;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;
    logic             commit;
    mdu_dec_t         dec;
    logic [19:0]      unused_instr_fields;

    assign unused_instr_fields = E_Instr[25:6];
    assign dec = mdu_decode(E_Instr[31:26], E_Instr[5:0]);

    mdu_arith u_arith (
        .op     (E_Instr[1:0]),
        .a      (E_RS),
        .b      (E_RT),
        .res_hi (arith_hi),
        .res_lo (arith_lo)
    );

    always_comb begin
        next_state = state;
        MDU_start  = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dec.mul) begin
                    MDU_start  = 1'b1;
                    next_state = ST_MUL;
                end else if (dec.div) begin
                    MDU_start  = 1'b1;
                    next_state = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (count == CNT_ONE) begin
                    commit     = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (MDU_start) begin
                count <= dec.div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                // Division by zero re-commits the current HI/LO, which cannot
                // change while the operation is in flight.
                if (dec.div && (E_RT == 32'd0)) begin
                    pend_hi <= hi;
                    pend_lo <= lo;
                end else begin
                    pend_hi <= arith_hi;
                    pend_lo <= arith_lo;
                end
            end else if (MDU_busy) begin
                count <= count - CNT_ONE;
            end

            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (state == ST_IDLE) begin
                if (dec.mthi) hi <= E_RS;
                if (dec.mtlo) lo <= E_RS;
            end
        end
    end

    assign MDU_busy  = (state != ST_IDLE);
    assign MDU_stall = MDU_start | MDU_busy;
    assign E_HI      = hi;
    assign E_LO      = lo;
    assign E_MDU_OUT = dec.mfhi ? hi : (dec.mflo ? lo : 32'd0);

    // The hazard unit keeps MDU instructions out of E while busy; such an
    // instruction is ignored by the logic above and flagged in simulation.
    mdu_issue_while_busy: assert property (@(posedge clk) disable iff (!reset)
        !(MDU_busy && (dec.mul || dec.div || dec.mthi || dec.mtlo || dec.mfhi || dec.mflo)))
        else $error("e_mdu: MDU instruction in E while an operation is in flight");

endmodule
